param_bus_counter: RTL and testbench
====================================

# param_bus_counter

Parametrised loadable up/down counter that succeeds the fixed 8-bit bus-increment counter. It samples the shared data bus to load a start value, then counts up or down under enable, with a selectable wrap or saturate policy, a programmable modulus and a compare register. It sits on the same bus-attached datapath, and its registered flags feed the controller as status/interrupt sources.

## Interface
- WIDTH, 8: counter, bus and compare width in bits (2..32).
- MAX_VALUE, 2**WIDTH-1: upper count bound (modulus-1); must be ≥1 and ≤2**WIDTH-1.
- SATURATE, 0: 0 = wrap at bounds, 1 = hold at bounds.
- LOAD_INC, 1: 1 = load writes data_bus_in+1 (legacy behaviour), 0 = load writes data_bus_in.

Ports:
- clock  input  1  single clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_bus_in  input  WIDTH  load / compare value.
- load  input  1  load counter from data_bus_in this cycle.
- cmp_load  input  1  load compare register from data_bus_in this cycle.
- enable  input  1  count one step this cycle.
- up_down  input  1  1 = count up, 0 = count down.
- ovf_clr  input  1  clear sticky overflow flag.
- cnt_out  output  WIDTH  current count, registered.
- tc  output  1  one-cycle terminal-count pulse, registered.
- ovf  output  1  sticky overflow/underflow flag.
- match  output  1  cnt_out equals compare register, registered.

## Operation
- Counter priority, highest first: reset > load > enable > hold.
- Load value: V = data_bus_in + LOAD_INC, computed in WIDTH+1 bits. If V > MAX_VALUE, the loaded value is 0 when SATURATE=0 (wrap) and MAX_VALUE when SATURATE=1. Load never sets tc or ovf.
- Count up, cnt_out < MAX_VALUE: cnt_out+1.
- Count up, cnt_out = MAX_VALUE: wrap mode → 0; saturate mode → hold MAX_VALUE. Either case is a boundary event.
- Count down, cnt_out > 0: cnt_out-1.
- Count down, cnt_out = 0: wrap mode → MAX_VALUE; saturate mode → hold 0. Either case is a boundary event.
- Boundary event: tc = 1 for exactly one cycle and ovf is set. In saturate mode, every enabled step attempted at the bound is a new event, so tc stays high while enable is held at the bound.
- ovf: sticky. Cleared by ovf_clr. If a boundary event and ovf_clr occur in the same cycle, set wins.
- Compare register cmp_q: cmp_load writes data_bus_in unmodified, with no clipping and no +1. cmp_load is independent of load; when both are asserted, both registers take the same bus value (the counter with its load rule applied).
- match = (next cnt_out == next cmp_q), registered, so it is coincident with the cnt_out it describes. It stays high while held.
- up_down is sampled only when enable=1 and load=0.

## Timing
- Reset (synchronous, one edge): cnt_out=0, cmp_q=0, tc=0, ovf=0, match=1 (0==0). Reset mid-count overrides load, enable and cmp_load in that cycle.
- Latency: cnt_out, tc, ovf and match all reflect the cycle-N inputs after edge N. There are no combinational input-to-output paths.
- tc deasserts on the next edge unless another boundary event occurs.
- Back-to-back loads: each load takes effect on its own edge. With load held high, the count stays at V.
- Direction reversal on consecutive enabled cycles is legal. There are no bubbles.

## Test plan
- Reset/legacy load (WIDTH=8, LOAD_INC=1): reset → cnt_out=0x00, ovf=0, match=1. Load data_bus_in=0x41 → cnt_out=0x42 next cycle.
- Wrap up (MAX_VALUE=9, SATURATE=0): load to 8 with LOAD_INC=0, then enable up for 3 cycles → 9, 0 (tc=1, ovf=1), 1 (tc=0, ovf=1).
- Saturate down (SATURATE=1): from 1, enable down for 3 cycles → 0, 0 (tc=1), 0 (tc=1), ovf=1. Assert ovf_clr with enable=0 → ovf=0.
- Load clipping (MAX_VALUE=9, LOAD_INC=1): data_bus_in=9 → wrap mode cnt_out=0, saturate mode cnt_out=9. tc=0 in both.
- Compare: cmp_load with 0x05, load 0x03 (LOAD_INC=0), enable up → match=0 at 4, match=1 at 5, match=0 at 6.
- Simultaneous events: boundary event with ovf_clr → ovf=1. reset asserted together with load=1, enable=1 → cnt_out=0, tc=0.

Source files
------------

// File: rtl/param_bus_counter.sv
// Loadable up/down counter fed from the shared data bus, with wrap or saturate
// bounds, a programmable modulus, a sticky overflow flag and a compare register.
module param_bus_counter #(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     MAX_VALUE = {WIDTH{1'b1}},
    parameter bit                   SATURATE  = 1'b0,
    parameter bit                   LOAD_INC  = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_bus_in,
    input  logic             load,
    input  logic             cmp_load,
    input  logic             enable,
    input  logic             up_down,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] cnt_out,
    output logic             tc,
    output logic             ovf,
    output logic             match
);

    localparam logic [WIDTH:0]   MAX_EXT  = {1'b0, MAX_VALUE};
    localparam logic [WIDTH-1:0] WRAP_LO  = SATURATE ? '0 : MAX_VALUE;
    localparam logic [WIDTH-1:0] WRAP_HI  = SATURATE ? MAX_VALUE : '0;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cmp_q, cmp_d;
    logic [WIDTH:0]   load_sum;
    logic [WIDTH-1:0] load_val;
    logic             boundary;

    // One extra bit so data_bus_in + 1 cannot silently wrap before the bound check.
    assign load_sum = {1'b0, data_bus_in} + (WIDTH+1)'(LOAD_INC);
    assign load_val = (load_sum > MAX_EXT) ? WRAP_HI : load_sum[WIDTH-1:0];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        cnt_d    = cnt_q;
        boundary = 1'b0;
        cmp_d    = cmp_load ? data_bus_in : cmp_q;
        if (load) begin
            cnt_d = load_val;
        end else if (enable) begin
            if (up_down) begin
                if (cnt_q == MAX_VALUE) begin
                    boundary = 1'b1;
                    cnt_d    = WRAP_HI;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    boundary = 1'b1;
                    cnt_d    = WRAP_LO;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            cnt_q <= '0;
            cmp_q <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            match <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            cmp_q <= cmp_d;
            tc    <= boundary;
            // A boundary event in the same cycle as a clear keeps the flag set.
            ovf   <= boundary | (ovf & ~ovf_clr);
            match <= (cnt_d == cmp_d);
        end
    end

    assign cnt_out = cnt_q;

endmodule

// File: tb/tb_param_bus_counter.sv
// Self-checking bench: five counter configurations share one stimulus stream and
// are compared every cycle against an arithmetic model, plus literal spot checks.
module tb_param_bus_counter;

    localparam int N = 5;
    // 0: default 8-bit legacy; 1: mod-10 wrap; 2: mod-10 saturate;
    // 3: mod-10 wrap +1 load; 4: mod-10 saturate +1 load
    localparam int P_MAX [N] = '{255, 9, 9, 9, 9};
    localparam bit P_SAT [N] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam bit P_INC [N] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_bus_in = '0;
    logic       load = 1'b0, cmp_load = 1'b0, enable = 1'b0, up_down = 1'b0, ovf_clr = 1'b0;

    logic [7:0] d_cnt   [N];
    logic       d_tc    [N];
    logic       d_ovf   [N];
    logic       d_match [N];

    int  errors = 0;
    int  checks = 0;

    int  m_cnt [N], m_cmp [N];
    bit  m_tc [N], m_ovf [N], m_match [N];
    bit  model_valid = 1'b0;

    always #5 clock = ~clock;

    for (genvar k = 0; k < N; k++) begin : g_dut
        param_bus_counter #(
            .WIDTH    (8),
            .MAX_VALUE(8'(P_MAX[k])),
            .SATURATE (P_SAT[k]),
            .LOAD_INC (P_INC[k])
        ) dut (
            .clock      (clock),
            .reset      (reset),
            .data_bus_in(data_bus_in),
            .load       (load),
            .cmp_load   (cmp_load),
            .enable     (enable),
            .up_down    (up_down),
            .ovf_clr    (ovf_clr),
            .cnt_out    (d_cnt[k]),
            .tc         (d_tc[k]),
            .ovf        (d_ovf[k]),
            .match      (d_match[k])
        );
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: counts on a 0..max number line with the boundary rules.
    always @(posedge clock) begin
        for (int k = 0; k < N; k++) begin
            if (reset) begin
                m_cnt[k] = 0; m_cmp[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; m_match[k] = 1;
            end else begin
                bit hit;
                int v;
                hit = 0;
                if (load) begin
                    v = int'(data_bus_in) + int'(P_INC[k]);
                    if (v > P_MAX[k]) v = P_SAT[k] ? P_MAX[k] : 0;
                    m_cnt[k] = v;
                end else if (enable) begin
                    if (up_down) begin
                        if (m_cnt[k] == P_MAX[k]) begin
                            hit = 1;
                            m_cnt[k] = P_SAT[k] ? P_MAX[k] : 0;
                        end else m_cnt[k] = m_cnt[k] + 1;
                    end else begin
                        if (m_cnt[k] == 0) begin
                            hit = 1;
                            m_cnt[k] = P_SAT[k] ? 0 : P_MAX[k];
                        end else m_cnt[k] = m_cnt[k] - 1;
                    end
                end
                if (cmp_load) m_cmp[k] = int'(data_bus_in);
                m_tc[k]    = hit;
                m_ovf[k]   = hit ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf[k]);
                m_match[k] = (m_cnt[k] == m_cmp[k]);
            end
        end
        model_valid = 1'b1;
    end

    always @(negedge clock) begin
        if (model_valid) begin
            for (int k = 0; k < N; k++) begin
                check($sformatf("model cnt[%0d]", k),   32'(d_cnt[k]),   32'(m_cnt[k]));
                check($sformatf("model tc[%0d]", k),    32'(d_tc[k]),    32'(m_tc[k]));
                check($sformatf("model ovf[%0d]", k),   32'(d_ovf[k]),   32'(m_ovf[k]));
                check($sformatf("model match[%0d]", k), 32'(d_match[k]), 32'(m_match[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset and legacy +1 load
        tick();
        check("reset cnt", 32'(d_cnt[0]), 32'h00);
        check("reset ovf", 32'(d_ovf[0]), 32'h0);
        check("reset tc", 32'(d_tc[0]), 32'h0);
        check("reset match", 32'(d_match[0]), 32'h1);
        reset = 1'b0;
        load = 1'b1; data_bus_in = 8'h41;
        tick();
        check("legacy load", 32'(d_cnt[0]), 32'h42);

        // Wrap up on mod-10 counter
        data_bus_in = 8'd8;
        tick();
        check("wrap load 8", 32'(d_cnt[1]), 32'd8);
        load = 1'b0; enable = 1'b1; up_down = 1'b1;
        tick();
        check("wrap cnt 9", 32'(d_cnt[1]), 32'd9);
        check("wrap tc at 9", 32'(d_tc[1]), 32'd0);
        tick();
        check("wrap cnt 0", 32'(d_cnt[1]), 32'd0);
        check("wrap tc", 32'(d_tc[1]), 32'd1);
        check("wrap ovf", 32'(d_ovf[1]), 32'd1);
        tick();
        check("wrap cnt 1", 32'(d_cnt[1]), 32'd1);
        check("wrap tc drop", 32'(d_tc[1]), 32'd0);
        check("wrap ovf sticky", 32'(d_ovf[1]), 32'd1);

        // Saturate down
        enable = 1'b0; load = 1'b1; data_bus_in = 8'd1; ovf_clr = 1'b1;
        tick();
        check("sat load 1", 32'(d_cnt[2]), 32'd1);
        check("sat ovf cleared", 32'(d_ovf[2]), 32'd0);
        load = 1'b0; ovf_clr = 1'b0; enable = 1'b1; up_down = 1'b0;
        tick();
        check("sat down 0", 32'(d_cnt[2]), 32'd0);
        check("sat tc first", 32'(d_tc[2]), 32'd0);
        tick();
        check("sat hold 0", 32'(d_cnt[2]), 32'd0);
        check("sat tc hold a", 32'(d_tc[2]), 32'd1);
        tick();
        check("sat hold 0 b", 32'(d_cnt[2]), 32'd0);
        check("sat tc hold b", 32'(d_tc[2]), 32'd1);
        check("sat ovf", 32'(d_ovf[2]), 32'd1);
        enable = 1'b0; ovf_clr = 1'b1;
        tick();
        check("sat ovf_clr", 32'(d_ovf[2]), 32'd0);
        check("sat tc idle", 32'(d_tc[2]), 32'd0);
        ovf_clr = 1'b0;

        // Load clipping
        load = 1'b1; data_bus_in = 8'd9;
        tick();
        check("clip wrap", 32'(d_cnt[3]), 32'd0);
        check("clip sat", 32'(d_cnt[4]), 32'd9);
        check("clip tc wrap", 32'(d_tc[3]), 32'd0);
        check("clip tc sat", 32'(d_tc[4]), 32'd0);

        // Compare
        load = 1'b0; cmp_load = 1'b1; data_bus_in = 8'h05;
        tick();
        cmp_load = 1'b0; load = 1'b1; data_bus_in = 8'h03;
        tick();
        check("cmp load 3", 32'(d_cnt[1]), 32'd3);
        load = 1'b0; enable = 1'b1; up_down = 1'b1;
        tick();
        check("cmp at 4", 32'(d_match[1]), 32'd0);
        tick();
        check("cmp at 5", 32'(d_match[1]), 32'd1);
        tick();
        check("cmp at 6", 32'(d_match[1]), 32'd0);

        // Boundary event together with ovf_clr: set wins
        enable = 1'b0; load = 1'b1; data_bus_in = 8'd9; ovf_clr = 1'b1;
        tick();
        check("pre-event ovf", 32'(d_ovf[1]), 32'd0);
        load = 1'b0; enable = 1'b1; up_down = 1'b1;
        tick();
        check("set wins tc", 32'(d_tc[1]), 32'd1);
        check("set wins ovf", 32'(d_ovf[1]), 32'd1);
        ovf_clr = 1'b0;

        // Reset overrides load, enable and cmp_load
        reset = 1'b1; load = 1'b1; cmp_load = 1'b1; data_bus_in = 8'h77;
        tick();
        check("reset ovr cnt", 32'(d_cnt[0]), 32'd0);
        check("reset ovr tc", 32'(d_tc[1]), 32'd0);
        check("reset ovr match", 32'(d_match[0]), 32'd1);
        reset = 1'b0; cmp_load = 1'b0;

        // Held load stays at V
        data_bus_in = 8'd4;
        tick();
        tick();
        check("held load", 32'(d_cnt[0]), 32'd5);

        // Mixed pattern: reversals, back-to-back loads, joint load/cmp_load, clears
        for (int i = 0; i < 48; i++) begin
            load        = (i % 11) < 2;
            cmp_load    = (i % 7) == 3 || (i % 11) == 0;
            enable      = (i % 5) != 4;
            up_down     = (i < 24) ? i[0] : ((i / 6) % 2 == 0);
            ovf_clr     = (i % 9) == 8;
            data_bus_in = 8'((i * 37) & 8'hFF);
            tick();
        end
        load = 1'b0; cmp_load = 1'b0; enable = 1'b0; ovf_clr = 1'b0;
        tick();
        @(negedge clock);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
